f3m_mult_arbiter: RTL and testbench

- Time-shares one GF(3^m) multiplier (f3m_mult style: clk, reset, a, b, c, done) between N requesters in the pairing datapath, e.g. the Miller-loop mu*nmu and v4*ny products and the final-exponentiation helpers.
- Latches the granted requester's operands and drives the multiplier's restart.
- Waits for the multiplier's done, captures the product and returns it with a one-cycle ack to the owner.
- Round-robin arbitration, one multiplication in flight at a time.

---
 rtl/f3m_mult_arbiter.sv | 144 ++++++++++++++
 tb/tb_f3m_mult_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/f3m_mult_arbiter.sv
// f3m_mult_arbiter: round-robin time-sharing of one GF(3^m) multiplier among N requesters.
// Define F3M_ARB_TIMEOUT_EN to add a RUN watchdog that sets sticky err and still acks the owner.
module f3m_mult_arbiter #(
  parameter int N = 4,
  parameter int M = 97,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N*2*M-1:0] op_a,
  input  logic [N*2*M-1:0] op_b,
  output logic [N-1:0]     ack,
  output logic [2*M-1:0]   result,
  output logic             busy,
  output logic             m_reset,
  output logic [2*M-1:0]   m_a,
  output logic [2*M-1:0]   m_b,
  input  logic [2*M-1:0]   m_c,
  input  logic             m_done,
  output logic             err
);
  localparam int W = 2 * M;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, rr_q, rr_d;
  logic [N-1:0] ack_q, ack_d;
  logic [W-1:0] result_q, result_d, m_a_q, m_a_d, m_b_q, m_b_d;
  logic busy_q, busy_d, m_reset_q, m_reset_d, first_q, first_d, found;
  int j;
`ifdef F3M_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d = rr_q;
    ack_d = '0;
    result_d = result_q;
    busy_d = busy_q;
    m_reset_d = m_reset_q;
    m_a_d = m_a_q;
    m_b_d = m_b_q;
    first_d = 1'b0;
    found = 1'b0;
    j = 0;
`ifdef F3M_ARB_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    case (state_q)
      IDLE: begin
        for (int i = 0; i < N; i++) begin
          j = (int'(rr_q) + i) % N;
          if (!found && req[j]) begin
            found = 1'b1;
            owner_d = IW'(j);
            m_a_d = op_a[j*W +: W];
            m_b_d = op_b[j*W +: W];
          end
        end
        busy_d = found ? 1'b1 : busy_q;
        state_d = found ? LOAD : IDLE;
      end
      LOAD: begin
        state_d = RUN;
        m_reset_d = 1'b0;
        first_d = 1'b1;
`ifdef F3M_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      RUN: begin
`ifdef F3M_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 16'd1;
`endif
        // A done seen in the first RUN cycle may be left over from the previous job.
        if (m_done && !first_q) begin
          result_d = m_c;
          state_d = DONE;
          m_reset_d = 1'b1;
          ack_d = N'(1) << owner_q;
        end
`ifdef F3M_ARB_TIMEOUT_EN
        else if (cnt_q + 16'd1 == 16'(TIMEOUT)) begin
          err_d = 1'b1;
          state_d = DONE;
          m_reset_d = 1'b1;
          ack_d = N'(1) << owner_q;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        busy_d = 1'b0;
        rr_d = (owner_q == IW'(N-1)) ? '0 : owner_q + IW'(1);
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q <= '0;
      ack_q <= '0;
      result_q <= '0;
      busy_q <= 1'b0;
      m_reset_q <= 1'b1;
      m_a_q <= '0;
      m_b_q <= '0;
      first_q <= 1'b0;
`ifdef F3M_ARB_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      ack_q <= ack_d;
      result_q <= result_d;
      busy_q <= busy_d;
      m_reset_q <= m_reset_d;
      m_a_q <= m_a_d;
      m_b_q <= m_b_d;
      first_q <= first_d;
`ifdef F3M_ARB_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end
  assign ack = ack_q;
  assign result = result_q;
  assign busy = busy_q;
  assign m_reset = m_reset_q;
  assign m_a = m_a_q;
  assign m_b = m_b_q;
endmodule

// File: tb/tb_f3m_mult_arbiter.sv
// tb_f3m_mult_arbiter: directed bench with a behavioural multiplier (product a*b, done after lat cycles).
module tb_f3m_mult_arbiter;
  localparam int N = 4;
  localparam int M = 97;
  localparam int W = 2 * M;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] op_a = '0, op_b = '0;
  logic [N-1:0] ack;
  logic [W-1:0] result, m_a, m_b, m_c;
  logic busy, m_reset, m_done, err;
  logic force1 = 1'b0, stuck0 = 1'b0;
  int lat = 5;
  int mcnt = 0;
  int total = 0, bad = 0;

  f3m_mult_arbiter #(.N(N), .M(M), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b), .ack(ack),
    .result(result), .busy(busy), .m_reset(m_reset), .m_a(m_a), .m_b(m_b),
    .m_c(m_c), .m_done(m_done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mcnt <= m_reset ? 0 : mcnt + 1;
  assign m_c = m_a * m_b;
  assign m_done = force1 | (!stuck0 && mcnt >= lat);

  task automatic set_op(input int k, input int a, input int b);
    op_a[k*W +: W] = W'(a);
    op_b[k*W +: W] = W'(b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    force1 = 1'b0;
    stuck0 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ack(input int max, output logic [N-1:0] got, output int cyc);
    got = '0;
    cyc = 0;
    while (cyc < max) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) begin
        got = ack;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL rst_ack: got %b want 0000", ack); end
    total++; if (result !== W'(0)) begin bad++; $display("FAIL rst_result: got %0d want 0", result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (m_reset !== 1'b1) begin bad++; $display("FAIL rst_m_reset: got %b want 1", m_reset); end
    total++; if (m_a !== W'(0) || m_b !== W'(0)) begin bad++; $display("FAIL rst_m_ab: got %0d/%0d want 0/0", m_a, m_b); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0 || m_reset !== 1'b1) begin bad++; $display("FAIL idle_noreq: busy %b m_reset %b want 0 1", busy, m_reset); end
  endtask

  task automatic test_single();
    logic [N-1:0] got;
    int c;
    do_reset();
    lat = 100;
    set_op(0, 1, 2);
    req = 4'b0001;
    @(negedge clk);
    total++; if (m_a !== W'(1) || m_b !== W'(2)) begin bad++; $display("FAIL single_ops: got %0d/%0d want 1/2", m_a, m_b); end
    total++; if (busy !== 1'b1 || m_reset !== 1'b1) begin bad++; $display("FAIL single_load: busy %b m_reset %b want 1 1", busy, m_reset); end
    set_op(0, 7, 9);
    req = 4'b0000;
    @(negedge clk);
    total++; if (m_reset !== 1'b0) begin bad++; $display("FAIL single_run: m_reset %b want 0", m_reset); end
    wait_ack(200, got, c);
    total++; if (got !== 4'b0001) begin bad++; $display("FAIL single_ack: got %b want 0001", got); end
    total++; if (c + 2 !== 103) begin bad++; $display("FAIL single_latency: got %0d want 103", c + 2); end
    total++; if (result !== W'(2)) begin bad++; $display("FAIL single_result: got %0d want 2", result); end
    @(negedge clk);
    total++; if (ack !== 4'b0000 || busy !== 1'b0 || m_reset !== 1'b1) begin bad++; $display("FAIL single_after: ack %b busy %b m_reset %b want 0000 0 1", ack, busy, m_reset); end
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || m_a !== W'(1) || result !== W'(2)) begin bad++; $display("FAIL single_hold: busy %b m_a %0d result %0d want 0 1 2", busy, m_a, result); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] got;
    int c;
    do_reset();
    lat = 5;
    for (int k = 0; k < N; k++) set_op(k, k + 3, k + 5);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack(50, got, c);
      total++; if (got !== 4'(1 << (n % 4))) begin bad++; $display("FAIL rr_order[%0d]: got %b want %b", n, got, 4'(1 << (n % 4))); end
      total++; if (c !== 8) begin bad++; $display("FAIL rr_latency[%0d]: got %0d want 8", n, c); end
      total++; if (result !== W'((n % 4 + 3) * (n % 4 + 5))) begin bad++; $display("FAIL rr_result[%0d]: got %0d want %0d", n, result, (n % 4 + 3) * (n % 4 + 5)); end
      @(negedge clk);
      total++; if (ack !== 4'b0000) begin bad++; $display("FAIL rr_pulse[%0d]: got %b want 0000", n, ack); end
    end
  endtask

  task automatic test_pointer_wrap();
    logic [N-1:0] got;
    logic [N-1:0] exp [3] = '{4'b0010, 4'b0100, 4'b0010};
    int c;
    do_reset();
    lat = 3;
    for (int k = 0; k < N; k++) set_op(k, k + 1, 2);
    req = 4'b1000;
    wait_ack(50, got, c);
    req = 4'b0110;
    total++; if (got !== 4'b1000) begin bad++; $display("FAIL wrap_first: got %b want 1000", got); end
    for (int n = 0; n < 3; n++) begin
      wait_ack(50, got, c);
      total++; if (got !== exp[n]) begin bad++; $display("FAIL wrap_grant[%0d]: got %b want %b", n, got, exp[n]); end
      total++; if (result !== W'(exp[n] == 4'b0010 ? 4 : 6)) begin bad++; $display("FAIL wrap_result[%0d]: got %0d want %0d", n, result, exp[n] == 4'b0010 ? 4 : 6); end
    end
  endtask

  task automatic test_stale_done();
    logic [N-1:0] got;
    int c;
    do_reset();
    lat = 10;
    force1 = 1'b1;
    set_op(0, 3, 4);
    req = 4'b0001;
    repeat (3) @(negedge clk);
    force1 = 1'b0;
    total++; if (ack !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL stale_ignored: ack %b busy %b want 0000 1", ack, busy); end
    wait_ack(50, got, c);
    total++; if (got !== 4'b0001 || c + 3 !== 13) begin bad++; $display("FAIL stale_true_done: ack %b at %0d want 0001 at 13", got, c + 3); end
    total++; if (result !== W'(12)) begin bad++; $display("FAIL stale_result: got %0d want 12", result); end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid_run();
    logic [N-1:0] got;
    int c;
    do_reset();
    lat = 100;
    set_op(1, 5, 6);
    req = 4'b0010;
    repeat (50) @(negedge clk);
    total++; if (busy !== 1'b1 || m_reset !== 1'b0) begin bad++; $display("FAIL midrst_running: busy %b m_reset %b want 1 0", busy, m_reset); end
    #2 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || m_reset !== 1'b1 || ack !== 4'b0000) begin bad++; $display("FAIL midrst_async: busy %b m_reset %b ack %b want 0 1 0000", busy, m_reset, ack); end
    total++; if (m_a !== W'(0) || m_b !== W'(0)) begin bad++; $display("FAIL midrst_ops: got %0d/%0d want 0/0", m_a, m_b); end
    repeat (2) @(negedge clk);
    lat = 5;
    reset = 1'b0;
    wait_ack(50, got, c);
    total++; if (got !== 4'b0010 || c !== 8) begin bad++; $display("FAIL midrst_restart: ack %b at %0d want 0010 at 8", got, c); end
    total++; if (result !== W'(30)) begin bad++; $display("FAIL midrst_result: got %0d want 30", result); end
    req = 4'b0000;
  endtask

  task automatic test_timeout();
    logic [N-1:0] got;
    int c;
    do_reset();
    lat = 3;
    set_op(0, 2, 3);
    req = 4'b0001;
`ifdef F3M_ARB_TIMEOUT_EN
    wait_ack(50, got, c);
    stuck0 = 1'b1;
    total++; if (result !== W'(6) || err !== 1'b0) begin bad++; $display("FAIL to_prejob: result %0d err %b want 6 0", result, err); end
    @(negedge clk);
    wait_ack(60, got, c);
    total++; if (got !== 4'b0001 || c !== 22) begin bad++; $display("FAIL to_ack: ack %b at %0d want 0001 at 22", got, c); end
    total++; if (err !== 1'b1 || result !== W'(6)) begin bad++; $display("FAIL to_err: err %b result %0d want 1 6", err, result); end
    req = 4'b0000;
    repeat (3) @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", err); end
`else
    stuck0 = 1'b1;
    got = '0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      got = got | ack;
    end
    total++; if (busy !== 1'b1 || got !== 4'b0000) begin bad++; $display("FAIL stuck_wait: busy %b acks %b want 1 0000", busy, got); end
    total++; if (err !== 1'b0 || m_reset !== 1'b0) begin bad++; $display("FAIL stuck_err: err %b m_reset %b want 0 0", err, m_reset); end
    c = 0;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_wrap();
    test_stale_done();
    test_reset_mid_run();
    test_timeout();
    do_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
